// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR/trap unit: CSR addresses, mstatus/mie/mip
// bit positions, and the write-op and mtvec-mode encodings.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;
   localparam int MIE_MTIE       = 7;
   localparam int MIP_MTIP       = 7;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SET   = 2'b10,
      OP_CLEAR = 2'b11
   } csr_op_e;

   typedef enum logic [1:0] {
      MODE_DIRECT   = 2'b00,
      MODE_VECTORED = 2'b01
   } mtvec_mode_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes; a half write
// takes precedence over the increment in the same cycle.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] value
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (wr_lo) begin
         value[31:0] <= wdata;
      end else if (wr_hi) begin
         value[63:32] <= wdata;
      end else if (inc) begin
         value <= value + 64'd1;
      end
   end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry / mret sequencing and a one-cycle redirect pulse.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters; otherwise they read as 0.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int               XLEN        = 32,
   parameter logic [XLEN-1:0]  MSTATUS_RST = 'h1800,
   parameter logic [XLEN-1:0]  MTVEC_RST   = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  logic [11:0]      rd_addr,
   output logic [XLEN-1:0]  rd_data,
   output logic             illegal_csr,
   input  logic             wr_en,
   input  logic [11:0]      wr_addr,
   input  logic [1:0]       wr_op,
   input  logic [XLEN-1:0]  wr_data,
   input  logic             trap_valid,
   input  logic [XLEN-1:0]  trap_pc,
   input  logic [XLEN-1:0]  trap_cause,
   input  logic             mret,
   input  logic             irq_timer,
   output logic             irq_pending,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   input  logic             retire
);

   logic [XLEN-1:0] mstatus, mtvec, mepc, mcause, mscratch, mie;
   logic            mip_mtip;
   logic [XLEN-1:0] mip_val;
   logic [63:0]     mcycle, minstret;
   logic [XLEN-1:0] wr_old, wr_new, trap_base, trap_target;
   logic            wr_go;

   function automatic logic [XLEN-1:0] csr_apply(input logic [XLEN-1:0] old,
                                                 input logic [XLEN-1:0] d,
                                                 input logic [1:0]      op);
      case (csr_op_e'(op))
         OP_WRITE: return d;
         OP_SET:   return old | d;
         OP_CLEAR: return old & ~d;
         default:  return old;
      endcase
   endfunction

   // Counter addresses stay legal in every build so software probing them never faults.
   function automatic logic csr_legal(input logic [11:0] a);
      case (a)
         CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MIP,
         CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] csr_value(input logic [11:0] a);
      case (a)
         CSR_MSTATUS:   return mstatus;
         CSR_MIE:       return mie;
         CSR_MTVEC:     return mtvec;
         CSR_MSCRATCH:  return mscratch;
         CSR_MEPC:      return mepc;
         CSR_MCAUSE:    return mcause;
         CSR_MIP:       return mip_val;
         CSR_MCYCLE:    return XLEN'(mcycle[31:0]);
         CSR_MCYCLEH:   return XLEN'(mcycle[63:32]);
         CSR_MINSTRET:  return XLEN'(minstret[31:0]);
         CSR_MINSTRETH: return XLEN'(minstret[63:32]);
         default:       return '0;
      endcase
   endfunction

   always_comb begin
      mip_val           = '0;
      mip_val[MIP_MTIP] = mip_mtip;
   end

   always_comb begin
      illegal_csr = rd_en && !csr_legal(rd_addr);
      rd_data     = (rd_en && csr_legal(rd_addr)) ? csr_value(rd_addr) : '0;
      wr_old      = csr_value(wr_addr);
      wr_new      = csr_apply(wr_old, wr_data, wr_op);
      wr_go       = wr_en && (wr_op != OP_NONE) && !trap_valid && !mret;
   end

   always_comb begin
      trap_base   = {mtvec[XLEN-1:2], 2'b00};
      trap_target = trap_base;
      if (mtvec[1:0] == MODE_VECTORED && trap_cause[XLEN-1])
         trap_target = trap_base + {trap_cause[XLEN-3:0], 2'b00};
   end

   assign irq_pending = mstatus[MSTATUS_MIE] & mie[MIE_MTIE] & mip_mtip;

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus        <= MSTATUS_RST;
         mtvec          <= MTVEC_RST;
         mepc           <= '0;
         mcause         <= '0;
         mscratch       <= '0;
         mie            <= '0;
         mip_mtip       <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= 1'b0;
         mip_mtip       <= irq_timer;
         if (trap_valid) begin
            mepc                                  <= {trap_pc[XLEN-1:2], 2'b00};
            mcause                                <= trap_cause;
            mstatus[MSTATUS_MPIE]                 <= mstatus[MSTATUS_MIE];
            mstatus[MSTATUS_MIE]                  <= 1'b0;
            mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
            redirect_valid                        <= 1'b1;
            redirect_pc                           <= trap_target;
         end else if (mret) begin
            mstatus[MSTATUS_MIE]  <= mstatus[MSTATUS_MPIE];
            mstatus[MSTATUS_MPIE] <= 1'b1;
            redirect_valid        <= 1'b1;
            redirect_pc           <= mepc;
         end else if (wr_go) begin
            case (wr_addr)
               CSR_MSTATUS:  mstatus  <= wr_new;
               CSR_MIE:      mie      <= wr_new;
               CSR_MSCRATCH: mscratch <= wr_new;
               CSR_MEPC:     mepc     <= {wr_new[XLEN-1:2], 2'b00};
               CSR_MCAUSE:   mcause   <= wr_new;
               // Reserved mode encodings collapse to direct.
               CSR_MTVEC:    mtvec    <= {wr_new[XLEN-1:2],
                                          (wr_new[1:0] == MODE_VECTORED) ? MODE_VECTORED : MODE_DIRECT};
               default: ;
            endcase
         end
      end
   end

`ifdef CSR_COUNTERS_EN
   csr_counter64 u_mcycle (
      .clk   (clk),
      .rst   (rst),
      .inc   (1'b1),
      .wr_lo (wr_go && wr_addr == CSR_MCYCLE),
      .wr_hi (wr_go && wr_addr == CSR_MCYCLEH),
      .wdata (wr_new[31:0]),
      .value (mcycle)
   );

   csr_counter64 u_minstret (
      .clk   (clk),
      .rst   (rst),
      .inc   (retire),
      .wr_lo (wr_go && wr_addr == CSR_MINSTRET),
      .wr_hi (wr_go && wr_addr == CSR_MINSTRETH),
      .wdata (wr_new[31:0]),
      .value (minstret)
   );
`else
   logic unused_retire;
   assign unused_retire = retire;
   assign mcycle        = '0;
   assign minstret      = '0;
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit; counter checks follow CSR_COUNTERS_EN.
module tb_csr_trap_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en;
   logic [11:0] rd_addr;
   logic [31:0] rd_data;
   logic        illegal_csr;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [1:0]  wr_op;
   logic [31:0] wr_data;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic        mret;
   logic        irq_timer;
   logic        irq_pending;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        retire;

   int total = 0;
   int bad   = 0;

   csr_trap_unit dut (
      .clk            (clk),
      .rst            (rst),
      .rd_en          (rd_en),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .illegal_csr    (illegal_csr),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_op          (wr_op),
      .wr_data        (wr_data),
      .trap_valid     (trap_valid),
      .trap_pc        (trap_pc),
      .trap_cause     (trap_cause),
      .mret           (mret),
      .irq_timer      (irq_timer),
      .irq_pending    (irq_pending),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .retire         (retire)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
      rd_en   = 1'b1;
      rd_addr = a;
      #1;
      chk(tag, rd_data, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_op   = op;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      wr_op = 2'b00;
   endtask

   initial begin
      rst = 1'b1; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_op = 2'b00;
      wr_data = '0; trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; mret = 1'b0;
      irq_timer = 1'b0; retire = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // reset state
      chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_illegal", {31'd0, illegal_csr}, 32'd0);
      chk("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
      rdchk("rst_mstatus", 12'h300, 32'h1800);
      rdchk("rst_mtvec", 12'h305, 32'h0);
      rdchk("rst_mepc", 12'h341, 32'h0);
      rdchk("illegal_data", 12'h7C0, 32'h0);
      chk("illegal_flag", {31'd0, illegal_csr}, 32'd1);
      rdchk("legal_data", 12'h300, 32'h1800);
      chk("legal_flag", {31'd0, illegal_csr}, 32'd0);

      // write / set / clear
      wr(12'h305, 2'b01, 32'h100);
      rdchk("mtvec_write", 12'h305, 32'h100);
      wr(12'h300, 2'b10, 32'h8);
      rdchk("mstatus_set", 12'h300, 32'h1808);
      wr(12'h300, 2'b11, 32'h8);
      rdchk("mstatus_clear", 12'h300, 32'h1800);
      wr(12'h341, 2'b01, 32'h7);
      rdchk("mepc_align", 12'h341, 32'h4);
      wr(12'h305, 2'b01, 32'h103);
      rdchk("mtvec_mode_sanitize", 12'h305, 32'h100);
      wr(12'h344, 2'b01, 32'hFFFF_FFFF);
      rdchk("mip_readonly", 12'h344, 32'h0);
      wr(12'h340, 2'b01, 32'hA5A5);
      wr(12'h340, 2'b10, 32'h0F00);
      rdchk("mscratch_set", 12'h340, 32'hAFA5);
      wr(12'h340, 2'b00, 32'h1234);
      rdchk("mscratch_noop", 12'h340, 32'hAFA5);

      // synchronous exception, direct mode
      wr(12'h300, 2'b10, 32'h8);
      trap_valid = 1'b1; trap_pc = 32'h8000_0012; trap_cause = 32'd11;
      tick();
      trap_valid = 1'b0;
      chk("exc_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      chk("exc_redirect_pc", redirect_pc, 32'h100);
      rdchk("exc_mepc", 12'h341, 32'h8000_0010);
      rdchk("exc_mcause", 12'h342, 32'd11);
      rdchk("exc_mstatus", 12'h300, 32'h1880);
      tick();
      chk("exc_pulse_end", {31'd0, redirect_valid}, 32'd0);

      // vectored timer interrupt and mret
      wr(12'h305, 2'b01, 32'h101);
      wr(12'h304, 2'b10, 32'h80);
      wr(12'h300, 2'b10, 32'h8);
      rdchk("irq_mstatus", 12'h300, 32'h1888);
      irq_timer = 1'b1;
      #1;
      chk("irq_not_yet", {31'd0, irq_pending}, 32'd0);
      tick();
      chk("irq_pending", {31'd0, irq_pending}, 32'd1);
      rdchk("mip_mtip", 12'h344, 32'h80);
      trap_valid = 1'b1; trap_pc = 32'h2000; trap_cause = 32'h8000_0007;
      tick();
      trap_valid = 1'b0;
      chk("irq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      chk("irq_redirect_pc", redirect_pc, 32'h11C);
      chk("irq_masked", {31'd0, irq_pending}, 32'd0);
      rdchk("irq_mstatus_after", 12'h300, 32'h1880);
      mret = 1'b1;
      tick();
      mret = 1'b0;
      chk("mret_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      chk("mret_redirect_pc", redirect_pc, 32'h2000);
      rdchk("mret_mstatus", 12'h300, 32'h1888);
      tick();
      chk("mret_pulse_end", {31'd0, redirect_valid}, 32'd0);
      irq_timer = 1'b0;

      // trap + mret + write in one cycle: trap wins
      trap_valid = 1'b1; trap_pc = 32'h3006; trap_cause = 32'd2; mret = 1'b1;
      wr_en = 1'b1; wr_addr = 12'h341; wr_op = 2'b01; wr_data = 32'h5550;
      tick();
      trap_valid = 1'b0; mret = 1'b0; wr_en = 1'b0; wr_op = 2'b00;
      chk("prio_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      chk("prio_redirect_pc", redirect_pc, 32'h100);
      rdchk("prio_mepc", 12'h341, 32'h3004);
      rdchk("prio_mcause", 12'h342, 32'd2);
      rdchk("prio_mstatus", 12'h300, 32'h1880);
      tick();
      chk("prio_pulse_end", {31'd0, redirect_valid}, 32'd0);

      // trap with a simultaneous mstatus write discards the write
      trap_valid = 1'b1; trap_pc = 32'h4000; trap_cause = 32'd3;
      wr_en = 1'b1; wr_addr = 12'h300; wr_op = 2'b01; wr_data = 32'h0;
      tick();
      trap_valid = 1'b0; wr_en = 1'b0; wr_op = 2'b00;
      chk("b2b_first_valid", {31'd0, redirect_valid}, 32'd1);
      rdchk("trap_wr_mstatus", 12'h300, 32'h1800);
      // back-to-back mret, with a dropped mscratch write
      mret = 1'b1;
      wr_en = 1'b1; wr_addr = 12'h340; wr_op = 2'b01; wr_data = 32'h0;
      tick();
      mret = 1'b0; wr_en = 1'b0; wr_op = 2'b00;
      chk("b2b_second_valid", {31'd0, redirect_valid}, 32'd1);
      chk("b2b_second_pc", redirect_pc, 32'h4000);
      rdchk("mret_drops_write", 12'h340, 32'hAFA5);
      rdchk("b2b_mstatus", 12'h300, 32'h1880);

      // reset during an event cancels the redirect
      trap_valid = 1'b1; trap_pc = 32'h5000; trap_cause = 32'd1; rst = 1'b1;
      tick();
      trap_valid = 1'b0; rst = 1'b0;
      chk("rst_cancel_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_cancel_pc", redirect_pc, 32'h0);
      rdchk("rst_cancel_mstatus", 12'h300, 32'h1800);
      rdchk("rst_cancel_mepc", 12'h341, 32'h0);

`ifdef CSR_COUNTERS_EN
      wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
      wr(12'hB80, 2'b01, 32'h0);
      tick();
      rdchk("mcycle_lo_carry", 12'hB00, 32'h0);
      chk("mcycle_legal", {31'd0, illegal_csr}, 32'd0);
      rdchk("mcycle_hi_carry", 12'hB80, 32'h1);
      retire = 1'b1;
      tick();
      tick();
      tick();
      retire = 1'b0;
      rdchk("minstret_lo", 12'hB02, 32'd3);
      rdchk("minstret_hi", 12'hB82, 32'd0);
`else
      wr(12'hB00, 2'b01, 32'h5);
      rdchk("mcycle_off_lo", 12'hB00, 32'h0);
      chk("mcycle_off_legal", {31'd0, illegal_csr}, 32'd0);
      retire = 1'b1;
      tick();
      retire = 1'b0;
      rdchk("minstret_off_lo", 12'hB02, 32'h0);
      rdchk("minstret_off_hi", 12'hB82, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
